// File: rtl/uart_rx.sv
// uart_rx: 8N1 (DATA_BITS-configurable) UART receiver.
//   The receiver generates bit timing from a free-running counter. The counter
//   is re-aligned on each start edge. The counter finds the middle of the start
//   bit, then samples each data bit and the stop bit one bit period apart.
//   A byte is delivered as a one-cycle rx_valid strobe.
// Ports:
//   sys_clk   - system clock; all logic runs on its rising edge
//   reset     - synchronous, active-high reset
//   rx        - asynchronous serial input; idles high
//   rx_data   - last correctly framed byte; holds until the next good frame
//   rx_valid  - one-cycle pulse: rx_data was updated this cycle
//   frame_err - one-cycle pulse: stop bit sampled low, byte discarded
//   busy      - high whenever the receiver is not idle
module uart_rx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;

    logic bit_tick, half_tick, last_bit;
    logic cnt_clr, shift_en, valid_set, ferr_set;

    // The synchronizer presets to 1 so that a reset is not seen as a start edge.
    always_ff @(posedge sys_clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    assign bit_tick  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (bit_cnt == CNT_W'(HALF_BIT - 1));
    assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            // A line that is high again at mid-start is treated as a glitch.
            START:   if (half_tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (bit_tick && last_bit) state_nxt = STOP;
            STOP:    if (bit_tick) state_nxt = rx_s ? IDLE : BRK;
            // After a framing error, wait for the line to release before
            // hunting again. A held-low break therefore reports only once.
            BRK:     if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    cnt_clr = 1'b1;
            // Re-zero at mid-start so that later ticks land mid-bit.
            START:   cnt_clr = half_tick;
            DATA:    shift_en = bit_tick;
            STOP: begin
                valid_set = bit_tick &&  rx_s;
                ferr_set  = bit_tick && !rx_s;
            end
            BRK:     cnt_clr = 1'b1;
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit-timing counter: wraps at the end of each bit period.
    always_ff @(posedge sys_clk) begin
        if (reset || cnt_clr) bit_cnt <= '0;
        else if (bit_tick)    bit_cnt <= '0;
        else                  bit_cnt <= bit_cnt + 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            bit_idx <= '0;
            shift   <= '0;
        end else if (state == START) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= valid_set;
            frame_err <= ferr_set;
            if (valid_set) rx_data <= shift;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-stimulus bench for uart_rx at its default parameters.
// A reference model predicts the outputs from absolute sample times that are
// measured from the detected start edge. The outputs are compared on every
// falling clock edge. Literal expectations check frame latency, spacing,
// busy duration and byte values.
module tb_uart_rx;
    localparam int CPB  = 217;
    localparam int HALF = 108;
    localparam int DB   = 8;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;

    uart_rx dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Edge counter, plus the inputs as they were seen at each rising edge.
    int   cyc = 0;
    logic rx_at_edge, rst_at_edge;
    always @(posedge sys_clk) begin
        cyc         <= cyc + 1;
        rx_at_edge  <= rx;
        rst_at_edge <= reset;
    end

    // Model state
    logic [1:0] m_dly;
    int         m_mode = 0;   // 0 hunting, 1 in frame, 2 waiting for line release
    int         t0;
    logic [7:0] m_shift;
    logic [7:0] exp_data;
    logic       exp_valid, exp_ferr;

    // Event log
    logic [7:0] vq[$];
    int         cq[$];
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         last_start;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic clear_log();
        vq.delete();
        cq.delete();
        ferr_cnt = 0;
        busy_cnt = 0;
    endtask

    always @(negedge sys_clk) begin
        logic rs;
        int   d, k;
        if (rst_at_edge) begin
            m_dly     = 2'b11;
            m_mode    = 0;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_data  = 8'h00;
        end else begin
            rs        = m_dly[1];
            m_dly     = {m_dly[0], rx_at_edge};
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            case (m_mode)
                0: if (!rs) begin t0 = cyc; m_mode = 1; end
                1: begin
                    d = cyc - t0;
                    if (d == HALF) begin
                        if (rs) m_mode = 0;
                    end else if (d > HALF && (d - HALF) % CPB == 0) begin
                        k = (d - HALF) / CPB;
                        if (k <= DB) m_shift[k-1] = rs;
                        else if (rs) begin
                            exp_data  = m_shift;
                            exp_valid = 1'b1;
                            m_mode    = 0;
                        end else begin
                            exp_ferr = 1'b1;
                            m_mode   = 2;
                        end
                    end
                end
                default: if (rs) m_mode = 0;
            endcase
        end
        checks++;
        if ({rx_valid, frame_err, busy, rx_data} !== {exp_valid, exp_ferr, (m_mode != 0), exp_data}) begin
            errors++;
            $display("FAIL outputs @cyc %0d: got v=%b fe=%b busy=%b data=%h want v=%b fe=%b busy=%b data=%h",
                     cyc, rx_valid, frame_err, busy, rx_data, exp_valid, exp_ferr, (m_mode != 0), exp_data);
        end
        if (rx_valid === 1'b1) begin vq.push_back(rx_data); cq.push_back(cyc); end
        if (frame_err === 1'b1) ferr_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // Called at a falling edge. Holds rx at v for per cycles and ends at a falling edge.
    task automatic drive_bit(input logic v, input int per);
        rx = v;
        repeat (per) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
        last_start = cyc;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop_bit, per);
    endtask

    initial begin
        int s0;
        logic seen3c;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        check("reset_outputs", {rx_valid, frame_err, busy}, 0);
        check("reset_rx_data", rx_data, 0);
        drive_bit(1'b1, 20);

        // 0x55: the stop sample is at 2061 cycles after the FSM sees the start.
        // The synchronizer adds 2 cycles and the registered strobe adds 1.
        clear_log();
        send_frame(8'h55, CPB, 1'b1);
        s0 = last_start;
        drive_bit(1'b1, 300);
        check("x55_count", vq.size(), 1);
        if (vq.size() == 1) begin
            check("x55_data", vq[0], 8'h55);
            check("x55_latency", cq[0] - s0, 2061 + 2 + 1);
        end
        check("x55_no_ferr", ferr_cnt, 0);

        // A 50-cycle low glitch is only rejected at the mid-start check, so
        // busy stays high for HALF_BIT cycles.
        clear_log();
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 300);
        check("glitch_valid", vq.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_busy_len", busy_cnt, HALF);
        check("glitch_idle", busy, 0);

        // The stop bit is low and the line then stays low: expect one frame_err,
        // and the previous byte is kept.
        clear_log();
        send_frame(8'hA3, CPB, 1'b0);
        drive_bit(1'b0, 3000);
        check("break_busy_held", busy, 1);
        drive_bit(1'b1, 300);
        check("break_ferr_once", ferr_cnt, 1);
        check("break_no_valid", vq.size(), 0);
        check("break_data_kept", rx_data, 8'h55);
        check("break_idle", busy, 0);

        // Back-to-back frames with no gap between them.
        clear_log();
        send_frame(8'h00, CPB, 1'b1);
        send_frame(8'hFF, CPB, 1'b1);
        send_frame(8'h81, CPB, 1'b1);
        drive_bit(1'b1, 300);
        check("b2b_count", vq.size(), 3);
        if (vq.size() == 3) begin
            check("b2b_d0", vq[0], 8'h00);
            check("b2b_d1", vq[1], 8'hFF);
            check("b2b_d2", vq[2], 8'h81);
            check("b2b_gap01", cq[1] - cq[0], 10 * CPB);
            check("b2b_gap12", cq[2] - cq[1], 10 * CPB);
        end

        // Reset pulse during data bit 4 of 0x3C. Its tail can be mis-framed,
        // and the model tracks that. 0x3C itself must never be delivered.
        clear_log();
        fork
            send_frame(8'h3C, CPB, 1'b1);
            begin
                repeat (5 * CPB + 100) @(negedge sys_clk);
                reset = 1'b1;
                @(negedge sys_clk);
                reset = 1'b0;
                check("midreset_outputs", {rx_valid, frame_err, busy}, 0);
                check("midreset_rx_data", rx_data, 0);
            end
        join
        drive_bit(1'b1, 2500);
        send_frame(8'h7E, CPB, 1'b1);
        drive_bit(1'b1, 300);
        seen3c = 1'b0;
        foreach (vq[i]) if (vq[i] == 8'h3C) seen3c = 1'b1;
        check("midreset_no_3c", seen3c, 0);
        check("midreset_has_valid", vq.size() > 0, 1);
        if (vq.size() > 0) check("midreset_7e", vq[vq.size()-1], 8'h7E);

        // Baud mismatch of about 1.8% in either direction.
        clear_log();
        send_frame(8'h96, 213, 1'b1);
        drive_bit(1'b1, 300);
        send_frame(8'h96, 221, 1'b1);
        drive_bit(1'b1, 300);
        check("tol_count", vq.size(), 2);
        if (vq.size() == 2) begin
            check("tol_fast", vq[0], 8'h96);
            check("tol_slow", vq[1], 8'h96);
        end
        check("tol_no_ferr", ferr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
